// File: rtl/frogger_pkg.sv
// frogger_pkg: shared types, key codes and playfield geometry for frog_motion.
// FROG_TIMER_EN (used in frog_motion) enables the per-life countdown.
package frogger_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOP,
        DYING,
        HOME
    } frog_state_e;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
    } frog_pos_t;

    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    localparam logic [10:0] GRID_STEP = 11'd40;
    localparam logic [10:0] HOP_STEP  = 11'd10;
    localparam int          HOP_FRAMES = 4;

    localparam logic [10:0] X_MIN = 11'd0;
    localparam logic [10:0] X_MAX = 11'd600;
    localparam logic [10:0] Y_MIN = 11'd40;
    localparam logic [10:0] Y_MAX = 11'd440;

    localparam logic [10:0] START_X = 11'd320;
    localparam logic [10:0] START_Y = 11'd440;

    localparam logic [10:0] HOME_X0 = 11'd120;
    localparam logic [10:0] HOME_X1 = 11'd280;
    localparam logic [10:0] HOME_X2 = 11'd480;

    localparam logic [10:0] RIVER_Y_MIN = 11'd80;
    localparam logic [10:0] RIVER_Y_MAX = 11'd200;

    localparam int          DEATH_HOLD = 30;
    localparam logic [10:0] LIFE_TIME  = 11'd1800;

    localparam logic [4:0] HOP_LAST   = 5'(HOP_FRAMES - 1);
    localparam logic [4:0] DEATH_LAST = 5'(DEATH_HOLD - 1);

    function automatic logic is_home_x(logic [10:0] x);
        return (x == HOME_X0) || (x == HOME_X1) || (x == HOME_X2);
    endfunction

    // A hop is legal only if its full 40 px landing cell stays inside the field.
    function automatic logic target_ok(dir_e d, frog_pos_t p);
        logic ok;
        ok = 1'b0;
        case (d)
            DIR_UP:    ok = p.y >= (Y_MIN + GRID_STEP);
            DIR_DOWN:  ok = (p.y + GRID_STEP) <= Y_MAX;
            DIR_LEFT:  ok = p.x >= (X_MIN + GRID_STEP);
            DIR_RIGHT: ok = (p.x + GRID_STEP) <= X_MAX;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic frog_pos_t hop_step(frog_pos_t p, dir_e d);
        frog_pos_t n;
        n = p;
        case (d)
            DIR_UP:    n.y = p.y - HOP_STEP;
            DIR_DOWN:  n.y = p.y + HOP_STEP;
            DIR_LEFT:  n.x = p.x - HOP_STEP;
            DIR_RIGHT: n.x = p.x + HOP_STEP;
            default:   n = p;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/frog_motion_if.sv
// frog_motion_if: game-side signal bundle of the frog motion block.
interface frog_motion_if;

    logic [7:0]  keycode;
    logic        frog_enable;
    logic        hazard;
    logic [3:0]  river_dx;
    logic [10:0] Frog_X;
    logic [10:0] Frog_Y;
    logic        dead_frog;
    logic        frog_home;
    logic [10:0] time_left;

    modport master (
        output keycode,
        output frog_enable,
        output hazard,
        output river_dx,
        input  Frog_X,
        input  Frog_Y,
        input  dead_frog,
        input  frog_home,
        input  time_left
    );

    modport slave (
        input  keycode,
        input  frog_enable,
        input  hazard,
        input  river_dx,
        output Frog_X,
        output Frog_Y,
        output dead_frog,
        output frog_home,
        output time_left
    );

endinterface

// File: rtl/frog_key_decode.sv
// frog_key_decode: HID keycode to hop direction plus edge-detected press strobe.
module frog_key_decode
    import frogger_pkg::*;
(
    input  logic       frame_clk,
    input  logic       game_restart_n,
    input  logic       en,
    input  logic [7:0] keycode,
    output dir_e       dir,
    output logic       press
);

    logic [7:0] prev_key;

    always_comb begin
        dir = DIR_NONE;
        unique case (1'b1)
            keycode == KEY_UP:    dir = DIR_UP;
            keycode == KEY_DOWN:  dir = DIR_DOWN;
            keycode == KEY_LEFT:  dir = DIR_LEFT;
            keycode == KEY_RIGHT: dir = DIR_RIGHT;
            default:              dir = DIR_NONE;
        endcase
    end

    // History only advances on live frames so a frozen frame cannot eat a press.
    always_ff @(posedge frame_clk or negedge game_restart_n) begin
        if (!game_restart_n) begin
            prev_key <= 8'h00;
        end else if (en) begin
            prev_key <= keycode;
        end
    end

    assign press = (dir != DIR_NONE) && (keycode != prev_key);

endmodule

// File: rtl/frog_motion.sv
// frog_motion: per-frame frog position, hop, drift, death and home FSM.
// Define FROG_TIMER_EN to enable the per-life countdown on time_left.
module frog_motion
    import frogger_pkg::*;
(
    input  logic         frame_clk,
    input  logic         game_restart_n,
    frog_motion_if.slave bus
);

    frog_state_e state_q, state_n;
    frog_pos_t   pos_q, pos_n;
    logic [4:0]  cnt_q, cnt_n;
    dir_e        hop_dir_q, hop_dir_n;
    logic        dead_q;
    logic        die;

    dir_e        key_dir;
    logic        key_press;
    logic        on_river;
    logic signed [11:0] x_d;
    logic        timer_out;

    frog_key_decode u_key (
        .frame_clk      (frame_clk),
        .game_restart_n (game_restart_n),
        .en             (bus.frog_enable),
        .keycode        (bus.keycode),
        .dir            (key_dir),
        .press          (key_press)
    );

    assign on_river = (pos_q.y >= RIVER_Y_MIN) && (pos_q.y <= RIVER_Y_MAX);
    assign x_d = $signed({1'b0, pos_q.x})
               + $signed({{8{bus.river_dx[3]}}, bus.river_dx});

`ifdef FROG_TIMER_EN
    logic [10:0] tl_q, tl_n;

    always_comb begin
        tl_n      = tl_q;
        timer_out = 1'b0;
        if (bus.frog_enable) begin
            if (state_q == IDLE || state_q == HOP) begin
                tl_n      = tl_q - 11'd1;
                timer_out = (tl_q == 11'd1);
            end else if (state_q == DYING && cnt_q == DEATH_LAST) begin
                tl_n = LIFE_TIME;
            end
        end
    end

    always_ff @(posedge frame_clk or negedge game_restart_n) begin
        if (!game_restart_n) begin
            tl_q <= LIFE_TIME;
        end else begin
            tl_q <= tl_n;
        end
    end

    assign bus.time_left = tl_q;
`else
    assign timer_out     = 1'b0;
    assign bus.time_left = '0;
`endif

    always_comb begin
        state_n   = state_q;
        pos_n     = pos_q;
        cnt_n     = cnt_q;
        hop_dir_n = hop_dir_q;
        die       = 1'b0;
        if (bus.frog_enable) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.hazard || timer_out) begin
                        die = 1'b1;
                    end else if (on_river && x_d[11]) begin
                        die     = 1'b1;
                        pos_n.x = X_MIN;
                    end else if (on_river && x_d > $signed({1'b0, X_MAX})) begin
                        die     = 1'b1;
                        pos_n.x = X_MAX;
                    end else begin
                        if (on_river) begin
                            pos_n.x = x_d[10:0];
                        end
                        if (key_press && target_ok(key_dir, pos_n)) begin
                            state_n   = HOP;
                            hop_dir_n = key_dir;
                            cnt_n     = '0;
                        end
                    end
                end
                HOP: begin
                    // Hazard beats the landing decision on the final frame.
                    if (bus.hazard || timer_out) begin
                        die = 1'b1;
                    end else begin
                        pos_n = hop_step(pos_q, hop_dir_q);
                        cnt_n = cnt_q + 5'd1;
                        if (cnt_q == HOP_LAST) begin
                            if (pos_n.y != Y_MIN) begin
                                state_n = IDLE;
                            end else if (is_home_x(pos_n.x)) begin
                                state_n = HOME;
                            end else begin
                                die = 1'b1;
                            end
                        end
                    end
                end
                DYING: begin
                    if (cnt_q == DEATH_LAST) begin
                        state_n = IDLE;
                        pos_n   = '{x: START_X, y: START_Y};
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 5'd1;
                    end
                end
                HOME: begin
                    state_n = HOME;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
            if (die) begin
                state_n = DYING;
                cnt_n   = '0;
            end
        end
    end

    always_ff @(posedge frame_clk or negedge game_restart_n) begin
        if (!game_restart_n) begin
            state_q   <= IDLE;
            pos_q     <= '{x: START_X, y: START_Y};
            cnt_q     <= '0;
            hop_dir_q <= DIR_NONE;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            pos_q     <= pos_n;
            cnt_q     <= cnt_n;
            hop_dir_q <= hop_dir_n;
            dead_q    <= die;
        end
    end

    assign bus.Frog_X    = pos_q.x;
    assign bus.Frog_Y    = pos_q.y;
    assign bus.dead_frog = dead_q;
    assign bus.frog_home = (state_q == HOME);

endmodule

// File: tb/tb_frog_motion.sv
// tb_frog_motion: table vectors, directed corner sequences and a randomized
// run compared every frame against a behavioural frog model.
module tb_frog_motion;

    logic frame_clk;
    logic game_restart_n;

    frog_motion_if bus ();

    frog_motion dut (
        .frame_clk      (frame_clk),
        .game_restart_n (game_restart_n),
        .bus            (bus)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int n_pass;
    int n_tot;

    function automatic void chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endfunction

    // Behavioural model: plain integers, hop as a vector and frame countdowns.
    localparam int PH_REST = 0;
    localparam int PH_JUMP = 1;
    localparam int PH_DEAD = 2;
    localparam int PH_SAFE = 3;

    int m_x, m_y, m_phase, m_left, m_vx, m_vy, m_time, m_prev;
    int m_dead;

    function automatic void model_reset();
        m_x = 320; m_y = 440; m_phase = PH_REST; m_left = 0;
        m_vx = 0; m_vy = 0; m_time = 1800; m_prev = 0; m_dead = 0;
    endfunction

    function automatic int exp_time();
`ifdef FROG_TIMER_EN
        return m_time;
`else
        return 0;
`endif
    endfunction

    function automatic void model_step();
        int k, dx, nx, vx, vy, tx, ty;
        bit newp, tmo, die;
        k = int'(bus.keycode);
        dx = $signed(bus.river_dx);
        m_dead = 0;
        if (!bus.frog_enable) return;
        vx = 0; vy = 0;
        case (k)
            'h1A: vy = -1;
            'h16: vy = 1;
            'h04: vx = -1;
            'h07: vx = 1;
            default: ;
        endcase
        newp = (vx != 0 || vy != 0) && k != m_prev;
        m_prev = k;
        tmo = 0; die = 0;
`ifdef FROG_TIMER_EN
        if (m_phase == PH_REST || m_phase == PH_JUMP) begin
            m_time--;
            tmo = (m_time == 0);
        end
`endif
        if (m_phase == PH_REST) begin
            if (bus.hazard || tmo) die = 1;
            else begin
                nx = m_x + ((m_y >= 80 && m_y <= 200) ? dx : 0);
                if (nx < 0) begin m_x = 0; die = 1; end
                else if (nx > 600) begin m_x = 600; die = 1; end
                else begin
                    m_x = nx;
                    tx = m_x + 40 * vx;
                    ty = m_y + 40 * vy;
                    if (newp && tx >= 0 && tx <= 600 && ty >= 40 && ty <= 440) begin
                        m_phase = PH_JUMP; m_left = 4; m_vx = vx; m_vy = vy;
                    end
                end
            end
        end else if (m_phase == PH_JUMP) begin
            if (bus.hazard || tmo) die = 1;
            else begin
                m_x += 10 * m_vx;
                m_y += 10 * m_vy;
                m_left--;
                if (m_left == 0) begin
                    if (m_y != 40) m_phase = PH_REST;
                    else if (m_x == 120 || m_x == 280 || m_x == 480) m_phase = PH_SAFE;
                    else die = 1;
                end
            end
        end else if (m_phase == PH_DEAD) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = PH_REST; m_x = 320; m_y = 440; m_time = 1800;
            end
        end
        if (die) begin
            m_phase = PH_DEAD; m_left = 30; m_dead = 1;
        end
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        model_step();
        #1;
        chk("model_x", int'(bus.Frog_X), m_x);
        chk("model_y", int'(bus.Frog_Y), m_y);
        chk("model_dead", int'(bus.dead_frog), m_dead);
        chk("model_home", int'(bus.frog_home), int'(m_phase == PH_SAFE));
        chk("model_time", int'(bus.time_left), exp_time());
    endtask

    task automatic do_reset(string tag);
        game_restart_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_rst_x"}, int'(bus.Frog_X), 320);
        chk({tag, "_rst_y"}, int'(bus.Frog_Y), 440);
        chk({tag, "_rst_dead"}, int'(bus.dead_frog), 0);
        chk({tag, "_rst_home"}, int'(bus.frog_home), 0);
        chk({tag, "_rst_time"}, int'(bus.time_left), exp_time());
        @(negedge frame_clk);
        game_restart_n = 1'b1;
    endtask

    task automatic hop(input logic [7:0] k);
        bus.keycode = k;
        repeat (5) tick();
        bus.keycode = 8'h00;
        tick();
    endtask

    typedef struct {
        logic [7:0] key;
        bit         en;
        bit         haz;
        int         ex;
        int         ey;
        int         ed;
    } vec_t;

    function automatic vec_t mk(logic [7:0] k, bit en, bit hz, int x, int y, int d);
        vec_t v;
        v.key = k; v.en = en; v.haz = hz; v.ex = x; v.ey = y; v.ed = d;
        return v;
    endfunction

    vec_t tbl[23];

    initial begin
        int pulses;
        int hold;
        logic [7:0] rk;

        n_pass = 0; n_tot = 0;
        game_restart_n = 1'b1;
        bus.keycode = 8'h00;
        bus.frog_enable = 1'b1;
        bus.hazard = 1'b0;
        bus.river_dx = 4'h0;
        model_reset();

        tbl[0]  = mk(8'h16, 1, 0, 320, 440, 0);
        tbl[1]  = mk(8'h1A, 1, 0, 320, 440, 0);
        tbl[2]  = mk(8'h1A, 1, 0, 320, 430, 0);
        tbl[3]  = mk(8'h1A, 1, 0, 320, 420, 0);
        tbl[4]  = mk(8'h1A, 1, 0, 320, 410, 0);
        tbl[5]  = mk(8'h1A, 1, 0, 320, 400, 0);
        tbl[6]  = mk(8'h1A, 1, 0, 320, 400, 0);
        tbl[7]  = mk(8'h00, 1, 0, 320, 400, 0);
        tbl[8]  = mk(8'h07, 1, 0, 320, 400, 0);
        tbl[9]  = mk(8'h07, 1, 0, 330, 400, 0);
        tbl[10] = mk(8'h07, 1, 0, 340, 400, 0);
        tbl[11] = mk(8'h07, 1, 0, 350, 400, 0);
        tbl[12] = mk(8'h07, 1, 0, 360, 400, 0);
        tbl[13] = mk(8'h07, 1, 0, 360, 400, 0);
        tbl[14] = mk(8'h04, 0, 0, 360, 400, 0);
        tbl[15] = mk(8'h04, 1, 0, 360, 400, 0);
        tbl[16] = mk(8'h04, 0, 0, 360, 400, 0);
        tbl[17] = mk(8'h04, 1, 0, 350, 400, 0);
        tbl[18] = mk(8'h04, 1, 0, 340, 400, 0);
        tbl[19] = mk(8'h04, 1, 0, 330, 400, 0);
        tbl[20] = mk(8'h04, 1, 0, 320, 400, 0);
        tbl[21] = mk(8'h00, 1, 1, 320, 400, 1);
        tbl[22] = mk(8'h00, 1, 0, 320, 400, 0);

        #2;
        do_reset("init");
        for (int i = 0; i < 23; i++) begin
            bus.keycode = tbl[i].key;
            bus.frog_enable = tbl[i].en;
            bus.hazard = tbl[i].haz;
            tick();
            chk($sformatf("tbl%0d_x", i), int'(bus.Frog_X), tbl[i].ex);
            chk($sformatf("tbl%0d_y", i), int'(bus.Frog_Y), tbl[i].ey);
            chk($sformatf("tbl%0d_dead", i), int'(bus.dead_frog), tbl[i].ed);
        end
        bus.keycode = 8'h00; bus.frog_enable = 1'b1; bus.hazard = 1'b0;

        // Held right key: exactly one hop.
        do_reset("held");
        bus.keycode = 8'h07;
        repeat (20) tick();
        chk("held_x", int'(bus.Frog_X), 360);
        chk("held_y", int'(bus.Frog_Y), 440);
        bus.keycode = 8'h00;

        // River drift off the left edge, clamp, single pulse, respawn.
        do_reset("river");
        repeat (9) hop(8'h1A);
        chk("river_y", int'(bus.Frog_Y), 80);
        bus.river_dx = 4'h8;
        repeat (39) tick();
        chk("river_x8", int'(bus.Frog_X), 8);
        bus.river_dx = 4'hC;
        tick();
        chk("river_x4", int'(bus.Frog_X), 4);
        tick();
        chk("river_x0", int'(bus.Frog_X), 0);
        chk("river_alive", int'(bus.dead_frog), 0);
        tick();
        chk("river_clamp", int'(bus.Frog_X), 0);
        chk("river_dead", int'(bus.dead_frog), 1);
        pulses = 0;
        repeat (29) begin
            tick();
            pulses += int'(bus.dead_frog);
        end
        chk("river_hold_x", int'(bus.Frog_X), 0);
        chk("river_extra_pulses", pulses, 0);
        tick();
        chk("respawn_x", int'(bus.Frog_X), 320);
        chk("respawn_y", int'(bus.Frog_Y), 440);
        bus.river_dx = 4'h0;

        // Landing in a home slot, then hazard is ignored.
        do_reset("home");
        hop(8'h04);
        repeat (9) hop(8'h1A);
        bus.keycode = 8'h1A;
        repeat (5) tick();
        chk("home_flag", int'(bus.frog_home), 1);
        chk("home_x", int'(bus.Frog_X), 280);
        chk("home_y", int'(bus.Frog_Y), 40);
        bus.keycode = 8'h00;
        bus.hazard = 1'b1;
        repeat (3) tick();
        chk("home_hold", int'(bus.frog_home), 1);
        chk("home_nodeath", int'(bus.dead_frog), 0);
        bus.hazard = 1'b0;

        // Landing on the top row outside a slot kills.
        do_reset("miss");
        repeat (9) hop(8'h1A);
        bus.keycode = 8'h1A;
        repeat (5) tick();
        chk("miss_dead", int'(bus.dead_frog), 1);
        chk("miss_y", int'(bus.Frog_Y), 40);
        chk("miss_home", int'(bus.frog_home), 0);
        bus.keycode = 8'h00;

        // Reset asserted mid-hop.
        do_reset("pre_mid");
        bus.keycode = 8'h1A;
        repeat (3) tick();
        chk("mid_y", int'(bus.Frog_Y), 420);
        do_reset("midhop");
        bus.keycode = 8'h00;
        tick();

`ifdef FROG_TIMER_EN
        do_reset("timer");
        repeat (1799) tick();
        chk("timer_last", int'(bus.time_left), 1);
        tick();
        chk("timer_dead", int'(bus.dead_frog), 1);
        chk("timer_zero", int'(bus.time_left), 0);
        repeat (30) tick();
        chk("timer_reload", int'(bus.time_left), 1800);
`else
        do_reset("notimer");
        repeat (100) tick();
        chk("notimer_time", int'(bus.time_left), 0);
        chk("notimer_alive", int'(bus.dead_frog), 0);
`endif

        // Randomized run against the model.
        do_reset("rand0");
        hold = 0;
        rk = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    rk = 8'h00;
                    2, 3, 4: rk = 8'h1A;
                    5:       rk = 8'h16;
                    6:       rk = 8'h04;
                    7:       rk = 8'h07;
                    default: rk = 8'($urandom_range(0, 255));
                endcase
                hold = $urandom_range(1, 6);
            end
            hold--;
            bus.keycode = rk;
            bus.frog_enable = ($urandom_range(0, 9) != 0);
            bus.hazard = ($urandom_range(0, 79) == 0);
            bus.river_dx = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 399) == 0) do_reset("rand");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
